// File: rtl/bhargava_pkg.sv
// Shared constants for the bhargava ingress path: byte width, FIFO depth and
// programmable-full threshold, plus a constant log2 helper.
package bhargava_pkg;

    localparam int MPEG_BYTE_W           = 8;
    localparam int FIFO_DEPTH            = 1024;
    localparam int FIFO_PROG_FULL_THRESH = 1020;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    localparam int FIFO_ADDR_W = clog2(FIFO_DEPTH);

endpackage

// File: rtl/mpeg_fifo_ram.sv
// Simple dual-port DEPTH x DATA_W RAM: synchronous write, registered synchronous
// read with read-before-write behaviour on an address collision.
module mpeg_fifo_ram
    import bhargava_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = clog2(FIFO_DEPTH),
    parameter int DATA_W = MPEG_BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; this register is the FIFO's output byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mpeg_stream_fifo.sv
// Ingress byte FIFO feeding the scrambling core, with programmable-full back-pressure
// and end-of-stream tracking. Define MPEG_FIFO_STATS_EN to add byte counters and
// sticky overflow/underflow flags.
module mpeg_stream_fifo
    import bhargava_pkg::*;
#(
    parameter int DEPTH            = FIFO_DEPTH,
    parameter int ADDR_W           = clog2(FIFO_DEPTH),
    parameter int PROG_FULL_THRESH = FIFO_PROG_FULL_THRESH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MPEG_BYTE_W-1:0] mpeg_in,
    input  logic                   mpeg_wr,
    input  logic                   stream_end,
    input  logic                   mpeg_rd,
    output logic [MPEG_BYTE_W-1:0] mpeg_out,
    output logic                   mpeg_valid,
    output logic                   mpeg_empty,
    output logic                   mpeg_prog_full,
    output logic [ADDR_W:0]        fifo_count,
    output logic                   stream_done
`ifdef MPEG_FIFO_STATS_EN
    ,
    output logic [31:0]            in_byte_cnt,
    output logic [31:0]            out_byte_cnt,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] THRESH_CNT = (ADDR_W + 1)'(PROG_FULL_THRESH);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              done_s;
    logic              valid_r;
    logic              empty_r;
    logic              prog_full_r;
    logic              end_latch_r;
    logic              done_r;

    // Accept decisions, next occupancy and next done state.
    always_comb begin
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        count_s  = count_r;
        done_s   = done_r;
        rd_acc_s = mpeg_rd && (count_r != {(ADDR_W + 1){1'b0}});
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        wr_acc_s = mpeg_wr && !done_r && ((count_r != FULL_CNT) || rd_acc_s);
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   count_s = count_r - {{ADDR_W{1'b0}}, 1'b1};
            default: count_s = count_r;
        endcase
        if (end_latch_r && (count_r == {(ADDR_W + 1){1'b0}}) && !valid_r && !wr_acc_s) begin
            done_s = 1'b1;
        end else begin
            done_s = done_r;
        end
    end

    // Pointers, occupancy, flags decoded from next occupancy, end latch and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= {ADDR_W{1'b0}};
            rd_ptr_r    <= {ADDR_W{1'b0}};
            count_r     <= {(ADDR_W + 1){1'b0}};
            valid_r     <= 1'b0;
            empty_r     <= 1'b1;
            prog_full_r <= 1'b0;
            end_latch_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            end
            count_r     <= count_s;
            valid_r     <= rd_acc_s;
            empty_r     <= (count_s == {(ADDR_W + 1){1'b0}});
            prog_full_r <= (count_s >= THRESH_CNT);
            end_latch_r <= end_latch_r | stream_end;
            done_r      <= done_s;
        end
    end

    mpeg_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (MPEG_BYTE_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r),
        .wr_data (mpeg_in),
        .rd_en   (rd_acc_s),
        .rd_addr (rd_ptr_r),
        .rd_data (mpeg_out)
    );

    assign mpeg_valid     = valid_r;
    assign mpeg_empty     = empty_r;
    assign mpeg_prog_full = prog_full_r;
    assign fifo_count     = count_r;
    assign stream_done    = done_r;

`ifdef MPEG_FIFO_STATS_EN
    // Accepted-byte counters (wrap at 2^32) and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_byte_cnt  <= 32'd0;
            out_byte_cnt <= 32'd0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                in_byte_cnt <= in_byte_cnt + 32'd1;
            end
            if (rd_acc_s) begin
                out_byte_cnt <= out_byte_cnt + 32'd1;
            end
            if (mpeg_wr && !wr_acc_s) begin
                overflow <= 1'b1;
            end
            if (mpeg_rd && (count_r == {(ADDR_W + 1){1'b0}})) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mpeg_stream_fifo.sv
// Self-checking bench for mpeg_stream_fifo: directed phases with random data, checked
// every cycle against a queue-based reference model.
module tb_mpeg_stream_fifo;
    import bhargava_pkg::*;

    localparam int DEPTH  = FIFO_DEPTH;
    localparam int THRESH = FIFO_PROG_FULL_THRESH;
    localparam int AW     = clog2(FIFO_DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    mpeg_in;
    logic          mpeg_wr;
    logic          stream_end;
    logic          mpeg_rd;
    logic [7:0]    mpeg_out;
    logic          mpeg_valid;
    logic          mpeg_empty;
    logic          mpeg_prog_full;
    logic [AW:0]   fifo_count;
    logic          stream_done;
`ifdef MPEG_FIFO_STATS_EN
    logic [31:0]   in_byte_cnt;
    logic [31:0]   out_byte_cnt;
    logic          overflow;
    logic          underflow;
`endif

    mpeg_stream_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .mpeg_in        (mpeg_in),
        .mpeg_wr        (mpeg_wr),
        .stream_end     (stream_end),
        .mpeg_rd        (mpeg_rd),
        .mpeg_out       (mpeg_out),
        .mpeg_valid     (mpeg_valid),
        .mpeg_empty     (mpeg_empty),
        .mpeg_prog_full (mpeg_prog_full),
        .fifo_count     (fifo_count),
        .stream_done    (stream_done)
`ifdef MPEG_FIFO_STATS_EN
        ,
        .in_byte_cnt    (in_byte_cnt),
        .out_byte_cnt   (out_byte_cnt),
        .overflow       (overflow),
        .underflow      (underflow)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  q[$];
    bit          m_valid;
    logic [7:0]  m_out;
    bit          m_end;
    bit          m_done;
    int unsigned m_in_cnt;
    int unsigned m_out_cnt;
    bit          m_ovf;
    bit          m_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid   = 1'b0;
        m_out     = 8'h00;
        m_end     = 1'b0;
        m_done    = 1'b0;
        m_in_cnt  = 0;
        m_out_cnt = 0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(mpeg_valid), 32'(m_valid));
        if (m_valid) begin
            check({tag, ".data"}, 32'(mpeg_out), 32'(m_out));
        end
        check({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
        check({tag, ".empty"}, 32'(mpeg_empty), 32'(q.size() == 0));
        check({tag, ".pfull"}, 32'(mpeg_prog_full), 32'(q.size() >= THRESH));
        check({tag, ".done"}, 32'(stream_done), 32'(m_done));
`ifdef MPEG_FIFO_STATS_EN
        check({tag, ".in_cnt"}, in_byte_cnt, m_in_cnt);
        check({tag, ".out_cnt"}, out_byte_cnt, m_out_cnt);
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".udf"}, 32'(underflow), 32'(m_udf));
`endif
    endtask

    // One clock with the given inputs, then model update and full comparison.
    task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit se,
                        input string tag);
        bit rd_acc;
        bit wr_acc;
        bit n_done;
        mpeg_wr    = wr;
        mpeg_in    = d;
        mpeg_rd    = rd;
        stream_end = se;
        @(posedge clk);
        rd_acc = rd && (q.size() > 0);
        wr_acc = wr && !m_done && ((q.size() < DEPTH) || rd_acc);
        n_done = m_done || (m_end && (q.size() == 0) && !m_valid && !wr_acc);
        if (wr && !wr_acc) m_ovf = 1'b1;
        if (rd && (q.size() == 0)) m_udf = 1'b1;
        if (wr_acc) m_in_cnt++;
        if (rd_acc) m_out_cnt++;
        m_valid = rd_acc;
        if (rd_acc) m_out = q.pop_front();
        if (wr_acc) q.push_back(d);
        m_done = n_done;
        if (se) m_end = 1'b1;
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".out"}, 32'(mpeg_out), 32'h0);
        check({tag, ".valid"}, 32'(mpeg_valid), 32'h0);
        check({tag, ".empty"}, 32'(mpeg_empty), 32'h1);
        check({tag, ".pfull"}, 32'(mpeg_prog_full), 32'h0);
        check({tag, ".count"}, 32'(fifo_count), 32'h0);
        check({tag, ".done"}, 32'(stream_done), 32'h0);
`ifdef MPEG_FIFO_STATS_EN
        check({tag, ".in_cnt"}, in_byte_cnt, 32'h0);
        check({tag, ".out_cnt"}, out_byte_cnt, 32'h0);
        check({tag, ".ovf"}, 32'(overflow), 32'h0);
        check({tag, ".udf"}, 32'(underflow), 32'h0);
`endif
    endtask

    // Asynchronous reset asserted between edges while a write/read burst is active.
    task automatic do_reset(input string tag);
        mpeg_wr = 1'b1;
        mpeg_rd = 1'b1;
        mpeg_in = 8'($urandom);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals({tag, ".async"});
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals({tag, ".held"});
        rst     = 1'b0;
        mpeg_wr = 1'b0;
        mpeg_rd = 1'b0;
        model_reset();
    endtask

    initial begin
        int pushed;
        int cyc;
        bit wr;
        bit rd;
        rst        = 1'b1;
        mpeg_in    = 8'h00;
        mpeg_wr    = 1'b0;
        mpeg_rd    = 1'b0;
        stream_end = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-burst, then 0x11/0x22/0x33 and a 1-cycle-latency read
        step(1'b1, 8'hAA, 1'b0, 1'b0, "pre");
        step(1'b1, 8'hBB, 1'b0, 1'b0, "pre");
        do_reset("rst1");
        step(1'b1, 8'h11, 1'b0, 1'b0, "t1.wr");
        step(1'b1, 8'h22, 1'b0, 1'b0, "t1.wr");
        step(1'b1, 8'h33, 1'b0, 1'b0, "t1.wr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t1.rd");
        check("t1.first", 32'(mpeg_out), 32'h11);
        step(1'b0, 8'h00, 1'b0, 1'b0, "t1.idle");

        // Fill past full
        do_reset("rst2");
        for (int i = 0; i < DEPTH + 6; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0, "t2.fill");
        end
        check("t2.sat", 32'(fifo_count), DEPTH);

        // Full with concurrent read/write, then drain in order
        step(1'b1, 8'hA5, 1'b1, 1'b0, "t3.rw");
        check("t3.count", 32'(fifo_count), DEPTH);
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "t3.drain");
        end
        check("t3.last", 32'(mpeg_out), 32'hA5);

        // Random push/pop of 3000 bytes across pointer wraps
        do_reset("rst3");
        pushed = 0;
        cyc    = 0;
        while ((pushed < 3000 || q.size() > 0 || m_valid) && cyc < 20000) begin
            wr = (pushed < 3000) && ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) != 0);
            if (wr && ((q.size() < DEPTH) || (rd && q.size() > 0))) pushed++;
            step(wr, 8'($urandom), rd, 1'b0, "t4.mix");
            cyc++;
        end
        check("t4.budget", 32'(fifo_count), 32'h0);
`ifdef MPEG_FIFO_STATS_EN
        check("t4.in3000", in_byte_cnt, 32'd3000);
        check("t4.out3000", out_byte_cnt, 32'd3000);
`endif

        // Empty read is ignored; pointers stay aligned
        step(1'b0, 8'h00, 1'b1, 1'b0, "t5.erd");
        step(1'b1, 8'h5C, 1'b0, 1'b0, "t5.wr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t5.rd");
        check("t5.data", 32'(mpeg_out), 32'h5C);

        // End of stream: 5 bytes, pulse end, drain, done sticks, late write dropped
        do_reset("rst4");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0, "t6.wr");
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, "t6.end");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "t6.rd");
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, "t6.tail");
        step(1'b0, 8'h00, 1'b0, 1'b0, "t6.tail");
        check("t6.done", 32'(stream_done), 32'h1);
        step(1'b1, 8'h77, 1'b0, 1'b0, "t6.late");
        step(1'b0, 8'h00, 1'b0, 1'b0, "t6.hold");
        check("t6.cnt0", 32'(fifo_count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
